// File: rtl/sa_feeder.sv
// ============================================================================
// Module  : sa_feeder
// Brief   : Streams FIFO vectors into a systolic array with a per-lane skew.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_feeder #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_vec,
    input  logic [NUM_LANES*DATA_W-1:0]   fifo_data,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    input  logic                          sa_ready,
    output logic [NUM_LANES*DATA_W-1:0]   sa_data,
    output logic [NUM_LANES-1:0]          sa_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int DRN_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CNT_W-1:0]              r_rem;
    logic [CNT_W-1:0]              w_rem_nxt;
    logic [DRN_W-1:0]              r_drn;
    logic [DRN_W-1:0]              w_drn_nxt;
    logic                          r_done;
    logic                          w_done_nxt;
    logic                          w_adv;
    logic                          w_pop;
    logic [NUM_LANES*DATA_W-1:0]   w_inj_data;

    assign w_adv      = sa_ready;
    // Never pop an empty FIFO: it would move its pointers anyway.
    assign w_pop      = (r_state == ST_STREAM) & sa_ready & ~fifo_empty & (r_rem != '0);
    assign w_inj_data = w_pop ? fifo_data : '0;

    assign fifo_rd_en = w_pop;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_drn   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_drn   <= w_drn_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_drn_nxt   = r_drn;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_adv) begin
                    if (num_vec != '0) begin
                        w_rem_nxt   = num_vec;
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (w_pop) begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        if (NUM_LANES == 1) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                            w_drn_nxt   = DRN_W'(NUM_LANES - 1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (w_adv) begin
                    w_drn_nxt = r_drn - DRN_W'(1);
                    if (r_drn == DRN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Lane i is a shift chain of i+1 stages; bubbles carry zero data.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] r_d [0:gi];
        logic              r_v [0:gi];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 0; k <= gi; k++) begin
                    r_d[k] <= '0;
                    r_v[k] <= 1'b0;
                end
            end else if (w_adv) begin
                r_d[0] <= w_inj_data[gi*DATA_W +: DATA_W];
                r_v[0] <= w_pop;
                for (int k = 1; k <= gi; k++) begin
                    r_d[k] <= r_d[k-1];
                    r_v[k] <= r_v[k-1];
                end
            end
        end

        assign sa_data[gi*DATA_W +: DATA_W] = r_d[gi];
        assign sa_valid[gi]                 = r_v[gi];
    end

endmodule

`default_nettype wire

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 The block SHALL take parameter NUM_LANES, default 4, giving the number of systolic-array rows fed, one lane per row.
REQ-002 The block SHALL take parameter DATA_W, default 8, giving the width in bits of one lane element.
REQ-003 The block SHALL take parameter CNT_W, default 8, giving the width of the vector counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to stream num_vec vectors.
REQ-007 num_vec  input  CNT_W  number of FIFO entries to stream; sampled with start.
REQ-008 fifo_data  input  NUM_LANES*DATA_W  show-ahead FIFO head entry; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 fifo_empty  input  1  FIFO empty flag.
REQ-010 fifo_rd_en  output  1  pop request to the upstream FIFO; combinational.
REQ-011 sa_ready  input  1  array advance enable; low freezes the feeder.
REQ-012 sa_data  output  NUM_LANES*DATA_W  skewed row data to the array; registered.
REQ-013 sa_valid  output  NUM_LANES  per-lane valid; registered.
REQ-014 busy  output  1  high when the state is not IDLE.
REQ-015 done  output  1  one-cycle completion pulse; registered.

Function
REQ-016 The block SHALL have the FSM states IDLE, STREAM and DRAIN.
REQ-017 In IDLE, start with num_vec!=0 SHALL load the remaining-vector count with num_vec and go to STREAM.
REQ-018 In IDLE, start with num_vec==0 SHALL assert done in the next cycle and remain in IDLE, with no FIFO pop.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 An advance SHALL be defined as sa_ready==1; with sa_ready==0, all registers SHALL hold and sa_data/sa_valid SHALL remain frozen.
REQ-021 fifo_rd_en SHALL equal (state==STREAM) & sa_ready & ~fifo_empty & (remaining!=0).
REQ-022 fifo_rd_en SHALL never be asserted while fifo_empty==1, because the FIFO advances its pointers on simultaneous read and write even when empty.
REQ-023 On each advance, the skew pipeline SHALL shift one step and inject a new column: fifo_data with valid=1 on a pop, else a bubble (data 0, valid 0).
REQ-024 Lane i SHALL present the injected column i+1 advances after injection: lane 0 uses 1 register, lane i uses i+1 registers.
REQ-025 sa_data lane i SHALL be 0 whenever sa_valid[i]==0.
REQ-026 The remaining-vector count SHALL decrement only on a pop; fifo_empty during STREAM SHALL insert bubbles without decrementing the count.
REQ-027 The advance carrying the final pop SHALL move the FSM to DRAIN with the drain count set to NUM_LANES-1.
REQ-028 If NUM_LANES==1, the advance carrying the final pop SHALL instead go to IDLE and assert done.
REQ-029 In DRAIN, each advance SHALL inject a bubble and decrement the drain count; fifo_rd_en SHALL be 0.
REQ-030 On the advance that takes the drain count to 0, the FSM SHALL go to IDLE and register done=1 for one cycle, coincident with the last lane presenting the final vector.
REQ-031 busy SHALL be 1 in STREAM and DRAIN and 0 in IDLE, including the cycle in which done is high.

Reset
REQ-032 While rstn==0, the FSM, all counters and every skew register SHALL clear asynchronously.
REQ-033 While rstn==0, sa_data=0, sa_valid=0, busy=0, done=0 and fifo_rd_en=0.
REQ-034 Reset asserted mid-stream SHALL abandon the stream with no done pulse; the first start after reset release SHALL be honoured normally.

Verification (NUM_LANES=4, DATA_W=8; cycle n follows rising edge n)
REQ-035 Bench SHALL cover: rstn low with random inputs -> all outputs 0 and fifo_rd_en=0.
REQ-036 Bench SHALL cover: FIFO holds A={0x11,0x12,0x13,0x14} then B={0x21,0x22,0x23,0x24}; start with num_vec=2 in cycle 0; sa_ready=1 -> fifo_rd_en=1 in cycles 1-2; lane i shows A in cycle 2+i and B in cycle 3+i; done=1 and busy=0 in cycle 6 only; sa_valid=0 in cycle 7.
REQ-037 Bench SHALL cover: the same run with fifo_empty=1 in cycle 2 -> fifo_rd_en=0 that cycle; B pops in cycle 3; lane 0 sa_valid=0 in cycle 3; done moves to cycle 7.
REQ-038 Bench SHALL cover: sa_ready=0 in cycles 3-5 of the base run -> sa_data, sa_valid and fifo_rd_en frozen or 0 in cycles 3-5; done moves to cycle 9.
REQ-039 Bench SHALL cover: start with num_vec=0 -> done=1 in the next cycle; busy and fifo_rd_en stay 0.
REQ-040 Bench SHALL cover: rstn pulsed low in cycle 4 of the base run -> immediate all-zero outputs and no done; a new start after release streams correctly.
